// File: rtl/kvazaar_pio_pkg.sv
// Shared register map and edge-select encodings for the Kvazaar_QSYS PIO slaves
// (yuv_ctrl output PIO and yuv_status input PIO).
package kvazaar_pio_pkg;

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_RSVD    = 2'd1;
  localparam logic [1:0] ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] ADDR_EDGECAP = 2'd3;

  localparam int unsigned EDGE_RISE = 0;
  localparam int unsigned EDGE_FALL = 1;
  localparam int unsigned EDGE_ANY  = 2;

  // True when a slave write strobe targets the given word address.
  function automatic logic pio_wr_hit(input logic       chipselect,
                                      input logic       write_n,
                                      input logic [1:0] address,
                                      input logic [1:0] target);
    return chipselect && !write_n && (address == target);
  endfunction

endpackage

// File: rtl/kvazaar_bit_sync.sv
// Multi-flop synchroniser bringing WIDTH asynchronous lines into clk.
module kvazaar_bit_sync #(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_sync
);

  logic [WIDTH-1:0] stage_q [STAGES];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < STAGES; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= data_in;
      for (int i = 1; i < STAGES; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign data_sync = stage_q[STAGES-1];

endmodule

// File: rtl/kvazaar_qsys_yuv_status.sv
// Avalon-MM input PIO returning accelerator status to the Nios II: synchronised
// data, per-bit edge capture and a maskable level interrupt. Read latency 1.
module kvazaar_qsys_yuv_status
  import kvazaar_pio_pkg::*;
#(
  parameter int unsigned WIDTH       = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned EDGE_TYPE   = 0,
  parameter int unsigned BIT_CLEAR   = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam int unsigned ArmCount = SYNC_STAGES + 1;
  localparam int unsigned ArmW     = $clog2(ArmCount + 1);

  logic [WIDTH-1:0] data_sync;
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] edge_q, edge_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] event_d;
  logic [WIDTH-1:0] clear_d;
  logic [31:0]      readdata_q, readdata_d;
  logic             irq_q, irq_d;
  logic [ArmW-1:0]  arm_cnt_q;
  logic             armed;
  logic             unused_writedata;

  assign unused_writedata = ^writedata;

  kvazaar_bit_sync #(
    .WIDTH  (WIDTH),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk       (clk),
    .reset_n   (reset_n),
    .data_in   (in_port),
    .data_sync (data_sync)
  );

  // Holds off edge detection until the sync chain and prev hold real samples,
  // so lines already high when reset releases are not seen as edges.
  assign armed = (arm_cnt_q == ArmW'(ArmCount));

  always_comb begin
    event_d = '0;
    if (EDGE_TYPE == EDGE_RISE) begin
      event_d = data_sync & ~prev_q;
    end else if (EDGE_TYPE == EDGE_FALL) begin
      event_d = ~data_sync & prev_q;
    end else begin
      event_d = data_sync ^ prev_q;
    end
    if (!armed) begin
      event_d = '0;
    end

    clear_d = '0;
    if (pio_wr_hit(chipselect, write_n, address, ADDR_EDGECAP)) begin
      clear_d = (BIT_CLEAR != 0) ? writedata[WIDTH-1:0] : '1;
    end
    // New events are ORed in after the clear so a coincident edge is not lost.
    edge_d = (edge_q & ~clear_d) | event_d;

    mask_d = mask_q;
    if (pio_wr_hit(chipselect, write_n, address, ADDR_IRQMASK)) begin
      mask_d = writedata[WIDTH-1:0];
    end

    irq_d = |(edge_d & mask_d);

    readdata_d = '0;
    case (address)
      ADDR_DATA:    readdata_d[WIDTH-1:0] = data_sync;
      ADDR_IRQMASK: readdata_d[WIDTH-1:0] = mask_q;
      ADDR_EDGECAP: readdata_d[WIDTH-1:0] = edge_q;
      default:      readdata_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_q     <= '0;
      edge_q     <= '0;
      mask_q     <= '0;
      irq_q      <= 1'b0;
      readdata_q <= '0;
      arm_cnt_q  <= '0;
    end else begin
      prev_q     <= data_sync;
      edge_q     <= edge_d;
      mask_q     <= mask_d;
      irq_q      <= irq_d;
      readdata_q <= readdata_d;
      if (!armed) begin
        arm_cnt_q <= arm_cnt_q + 1'b1;
      end
    end
  end

  assign readdata = readdata_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_kvazaar_qsys_yuv_status.sv
// Directed bench: default instance (rising, write-1-to-clear) and an any-edge,
// clear-all instance sharing clock and reset.
module tb_kvazaar_qsys_yuv_status;

  logic        clk;
  logic        reset_n;

  logic [1:0]  address_a;
  logic        chipselect_a;
  logic        write_n_a;
  logic [31:0] writedata_a;
  logic [3:0]  in_port_a;
  logic [31:0] readdata_a;
  logic        irq_a;

  logic [1:0]  address_b;
  logic        chipselect_b;
  logic        write_n_b;
  logic [31:0] writedata_b;
  logic [3:0]  in_port_b;
  logic [31:0] readdata_b;
  logic        irq_b;

  int checks;
  int failures;

  kvazaar_qsys_yuv_status #(
    .WIDTH(4), .SYNC_STAGES(2), .EDGE_TYPE(0), .BIT_CLEAR(1)
  ) u_dut_a (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address_a),
    .chipselect (chipselect_a),
    .write_n    (write_n_a),
    .writedata  (writedata_a),
    .in_port    (in_port_a),
    .readdata   (readdata_a),
    .irq        (irq_a)
  );

  kvazaar_qsys_yuv_status #(
    .WIDTH(4), .SYNC_STAGES(2), .EDGE_TYPE(2), .BIT_CLEAR(0)
  ) u_dut_b (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address_b),
    .chipselect (chipselect_b),
    .write_n    (write_n_b),
    .writedata  (writedata_b),
    .in_port    (in_port_b),
    .readdata   (readdata_b),
    .irq        (irq_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input bit sel_b, input logic [1:0] addr, input logic [31:0] data);
    if (sel_b) begin
      address_b = addr; writedata_b = data; chipselect_b = 1'b1; write_n_b = 1'b0;
    end else begin
      address_a = addr; writedata_a = data; chipselect_a = 1'b1; write_n_a = 1'b0;
    end
    tick();
    chipselect_a = 1'b0; write_n_a = 1'b1;
    chipselect_b = 1'b0; write_n_b = 1'b1;
  endtask

  task automatic bus_read(input bit sel_b, input logic [1:0] addr, output logic [31:0] data);
    if (sel_b) address_b = addr;
    else       address_a = addr;
    tick();
    data = sel_b ? readdata_b : readdata_a;
  endtask

  logic [31:0] rd;

  initial begin
    checks = 0;
    failures = 0;
    reset_n = 1'b0;
    address_a = 2'd0; chipselect_a = 1'b0; write_n_a = 1'b1; writedata_a = '0;
    address_b = 2'd0; chipselect_b = 1'b0; write_n_b = 1'b1; writedata_b = '0;
    in_port_a = 4'hF;
    in_port_b = 4'h0;

    // 1: lines high through reset release must not register as edges.
    ticks(3);
    check("reset_readdata", readdata_a, 32'h0);
    check("reset_irq", {31'b0, irq_a}, 32'h0);
    reset_n = 1'b1;
    address_a = 2'd3;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("arm_irq_low", {31'b0, irq_a}, 32'h0);
      check("arm_edgecap_zero", readdata_a, 32'h0);
    end
    bus_read(1'b0, 2'd0, rd);
    check("data_read_F", rd, 32'h0000000F);
    bus_read(1'b0, 2'd2, rd);
    check("mask_reset", rd, 32'h0);

    // Writes to data/reserved are ignored; reserved reads zero.
    bus_write(1'b0, 2'd0, 32'hFFFF_FFF0);
    bus_write(1'b0, 2'd1, 32'hFFFF_FFFF);
    bus_read(1'b0, 2'd1, rd);
    check("reserved_zero", rd, 32'h0);
    bus_read(1'b0, 2'd2, rd);
    check("mask_unchanged", rd, 32'h0);

    // 2: rising edges on bits 0/1 with mask 0101.
    bus_write(1'b0, 2'd2, 32'hFFFF_FFF5);
    bus_read(1'b0, 2'd2, rd);
    check("mask_read", rd, 32'h5);
    in_port_a = 4'h0;
    ticks(4);
    bus_read(1'b0, 2'd3, rd);
    check("falls_ignored", rd, 32'h0);
    in_port_a = 4'h3;
    ticks(2);
    check("irq_before_latency", {31'b0, irq_a}, 32'h0);
    tick();
    check("irq_at_latency", {31'b0, irq_a}, 32'h1);
    tick();
    check("edgecap_0011", readdata_a, 32'h3);

    // 3: write-1-to-clear per bit.
    bus_write(1'b0, 2'd3, 32'h1);
    check("irq_after_clear0", {31'b0, irq_a}, 32'h0);
    bus_read(1'b0, 2'd3, rd);
    check("edgecap_0010", rd, 32'h2);
    bus_write(1'b0, 2'd3, 32'h2);
    bus_read(1'b0, 2'd3, rd);
    check("edgecap_cleared", rd, 32'h0);

    // 4: clear of bit1 in the same clk as a new rising event on bit1.
    in_port_a = 4'h1;
    ticks(4);
    in_port_a = 4'h3;
    ticks(2);
    bus_write(1'b0, 2'd3, 32'h2);
    bus_read(1'b0, 2'd3, rd);
    check("set_wins_clear", rd, 32'h2);
    check("irq_bit1_masked", {31'b0, irq_a}, 32'h0);
    bus_write(1'b0, 2'd3, 32'h2);
    bus_read(1'b0, 2'd3, rd);
    check("bit1_cleared", rd, 32'h0);

    // 5: any-edge, clear-all instance.
    bus_write(1'b1, 2'd2, 32'h8);
    in_port_b = 4'h8;
    ticks(4);
    bus_read(1'b1, 2'd3, rd);
    check("any_rise_bit3", rd, 32'h8);
    check("any_irq_rise", {31'b0, irq_b}, 32'h1);
    bus_write(1'b1, 2'd3, 32'h0);
    bus_read(1'b1, 2'd3, rd);
    check("any_clear_all", rd, 32'h0);
    check("any_irq_cleared", {31'b0, irq_b}, 32'h0);
    in_port_b = 4'h0;
    ticks(4);
    bus_read(1'b1, 2'd3, rd);
    check("any_fall_bit3", rd, 32'h8);
    bus_write(1'b1, 2'd3, 32'h0);
    bus_read(1'b1, 2'd3, rd);
    check("any_fall_cleared", rd, 32'h0);

    // 6: reset mid-operation with irq asserted.
    in_port_a = 4'h0;
    ticks(4);
    in_port_a = 4'h1;
    ticks(4);
    check("irq_before_reset", {31'b0, irq_a}, 32'h1);
    bus_read(1'b0, 2'd2, rd);
    check("mask_before_reset", rd, 32'h5);
    reset_n = 1'b0;
    #1;
    check("reset_irq_drop", {31'b0, irq_a}, 32'h0);
    check("reset_readdata_drop", readdata_a, 32'h0);
    tick();
    reset_n = 1'b1;
    bus_read(1'b0, 2'd2, rd);
    check("mask_after_reset", rd, 32'h0);
    ticks(10);
    bus_read(1'b0, 2'd3, rd);
    check("rearm_no_edge", rd, 32'h0);
    check("rearm_irq_low", {31'b0, irq_a}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
